frame_buffer: RTL and testbench
===============================

// Module: frame_buffer
// PURPOSE
//   Single-port-addressed 2D pixel store (column x row) for the edge-detection pipeline.
//   Holds a sliding window of image rows (default 3 lines of 640 pixels).
//   Sits between the colorspace stage and the convolution kernel.
//   Writes and reads are synchronous and addressed by (column, row).
// PARAMETERS
//   P_P_COLUMNS      640  pixels per row; column address width = $clog2(P_P_COLUMNS)
//   P_P_ROWS         3    rows stored; row address width = $clog2(P_P_ROWS)
//   P_P_PIXEL_DEPTH  24   bits per pixel, {R,G,B} with 8 bits each at default
// PORTS
//   I_CLK           in   1                     single clock; all logic on rising edge
//   I_RESET         in   1                     synchronous, active-high reset
//   I_PIXEL_COL     in   $clog2(P_P_COLUMNS)   column address
//   I_PIXEL_ROW     in   $clog2(P_P_ROWS)      row address
//   I_PIXEL         in   P_P_PIXEL_DEPTH       write data
//   I_WRITE_ENABLE  in   1                     write I_PIXEL to (col,row) this edge
//   I_READ_ENABLE   in   1                     load O_PIXEL from (col,row) this edge
//   O_PIXEL         out  P_P_PIXEL_DEPTH       registered read data
// BEHAVIOUR
//   - Reset (I_RESET=1 at rising edge): O_PIXEL <= 0. Writes are suppressed that cycle.
//     Memory array is NOT cleared. Contents are undefined until written.
//   - Reset mid-operation: any write or read presented in a reset cycle is dropped.
//     Operation resumes on the first edge with I_RESET=0.
//   - Write: at rising edge with I_WRITE_ENABLE=1, mem[row][col] <= I_PIXEL. Latency 1.
//     The new value is readable from the next edge onward.
//   - Read: at rising edge with I_READ_ENABLE=1, O_PIXEL <= mem[row][col].
//     O_PIXEL is valid after the edge (1-cycle latency).
//   - Read idle: with I_READ_ENABLE=0, O_PIXEL holds its last value.
//   - Simultaneous read and write, same address: read-before-write.
//     O_PIXEL gets the old contents; memory takes I_PIXEL.
//   - Simultaneous read and write, different addresses: both are performed.
//   - Out-of-range address (col >= P_P_COLUMNS or row >= P_P_ROWS, e.g. col 640..1023, row 3):
//     writes are ignored and memory is unchanged; reads load O_PIXEL <= 0.
//   - No handshake or backpressure. Enables are level-sampled every edge.
//   - No wrap-around of addresses. The caller owns row rotation.
// STRUCTURE
//   - Shared package edge_detect_pkg holds:
//     - default geometry constants: COLUMNS=640, ROWS=3, PIXEL_DEPTH=24, SUBPIXEL_DEPTH=8
//     - the pixel_t typedef (packed {r,g,b})
//     - the color constants WHITE=24'hFFFFFF and RED=24'hFF0000
//   - One natural sub-module, frame_buffer_line: a 1-row RAM of P_P_COLUMNS x depth.
//     - One write port and one registered read port.
//     - Instantiated P_P_ROWS times via generate.
//     - I_PIXEL_ROW decodes to the per-line write enables.
//     - A row-select mux feeds O_PIXEL.
//   - The address range check lives in the top level.
// TESTING
//   1. Reset 1 cycle, no enables -> O_PIXEL == 24'h000000 after reset, holds with reads idle.
//   2. Write (0,0)=24'hFFFFFF, next cycle read (0,0) -> O_PIXEL == 24'hFFFFFF one edge later.
//   3. Write (639,2)=24'hFF0000, then read (639,2) -> 24'hFF0000; re-read (0,0) -> 24'hFFFFFF still.
//   4. Same-edge read+write (5,1): old 24'h123456, new 24'hABCDEF -> O_PIXEL 24'h123456.
//      Next read -> 24'hABCDEF.
//   5. Write col 700 / row 3 with 24'h00FF00 -> no existing location changes; read col 700 -> O_PIXEL == 0.
//   6. Assert reset together with a write of (1,1)=24'h0000FF -> O_PIXEL==0, write dropped.
//      Prior (1,1) value reads back unchanged.

Source files
------------

// File: rtl/edge_detect_pkg.sv
// Shared geometry, pixel type and colour constants for the edge-detection pipeline.
package edge_detect_pkg;

  localparam int COLUMNS        = 640;
  localparam int ROWS           = 3;
  localparam int PIXEL_DEPTH    = 24;
  localparam int SUBPIXEL_DEPTH = 8;

  typedef struct packed {
    logic [SUBPIXEL_DEPTH-1:0] r;
    logic [SUBPIXEL_DEPTH-1:0] g;
    logic [SUBPIXEL_DEPTH-1:0] b;
  } pixel_t;

  localparam pixel_t WHITE = 24'hFFFFFF;
  localparam pixel_t RED   = 24'hFF0000;

endpackage

// File: rtl/frame_buffer_line.sv
// One image row: a simple RAM with one write port and one registered read port.
module frame_buffer_line
  import edge_detect_pkg::*;
#(
  parameter int P_P_COLUMNS     = COLUMNS,
  parameter int P_P_PIXEL_DEPTH = PIXEL_DEPTH,
  parameter int COL_W           = $clog2(P_P_COLUMNS)
) (
  input  logic                       clk,
  input  logic [COL_W-1:0]           col,
  input  logic [P_P_PIXEL_DEPTH-1:0] wr_data,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [P_P_PIXEL_DEPTH-1:0] rd_data
);

  logic [P_P_PIXEL_DEPTH-1:0] mem [P_P_COLUMNS];

  // Read samples the array before the write lands: read-before-write on the same column.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[col];
    end
    if (wr_en) begin
      mem[col] <= wr_data;
    end
  end

endmodule

// File: rtl/frame_buffer.sv
// Sliding-window line store addressed by (column, row); out-of-range accesses are dropped.
module frame_buffer
  import edge_detect_pkg::*;
#(
  parameter int P_P_COLUMNS     = COLUMNS,
  parameter int P_P_ROWS        = ROWS,
  parameter int P_P_PIXEL_DEPTH = PIXEL_DEPTH
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic [$clog2(P_P_COLUMNS)-1:0] I_PIXEL_COL,
  input  logic [$clog2(P_P_ROWS)-1:0]    I_PIXEL_ROW,
  input  logic [P_P_PIXEL_DEPTH-1:0]     I_PIXEL,
  input  logic                           I_WRITE_ENABLE,
  input  logic                           I_READ_ENABLE,
  output logic [P_P_PIXEL_DEPTH-1:0]     O_PIXEL
);

  localparam int COL_W = $clog2(P_P_COLUMNS);
  localparam int ROW_W = $clog2(P_P_ROWS);

  // No handshake: both enables are level-sampled on every rising edge, and a
  // reset cycle swallows whatever access is presented alongside it.
  logic                       in_range;
  logic                       wr_ok;
  logic                       rd_ok;
  logic [P_P_PIXEL_DEPTH-1:0] line_q [P_P_ROWS];
  logic                       sel_valid;
  logic [ROW_W-1:0]           sel_row;

  assign in_range = (32'(I_PIXEL_COL) < P_P_COLUMNS) && (32'(I_PIXEL_ROW) < P_P_ROWS);
  assign wr_ok    = I_WRITE_ENABLE && !I_RESET && in_range;
  assign rd_ok    = I_READ_ENABLE  && !I_RESET && in_range;

  for (genvar r = 0; r < P_P_ROWS; r++) begin : g_line
    frame_buffer_line #(
      .P_P_COLUMNS    (P_P_COLUMNS),
      .P_P_PIXEL_DEPTH(P_P_PIXEL_DEPTH),
      .COL_W          (COL_W)
    ) u_line (
      .clk    (I_CLK),
      .col    (I_PIXEL_COL),
      .wr_data(I_PIXEL),
      .wr_en  (wr_ok && (I_PIXEL_ROW == ROW_W'(r))),
      .rd_en  (rd_ok && (I_PIXEL_ROW == ROW_W'(r))),
      .rd_data(line_q[r])
    );
  end

  // Remember which line the last read targeted; an out-of-range read or reset
  // clears sel_valid so the output reads as zero until the next good read.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      sel_valid <= 1'b0;
      sel_row   <= '0;
    end else if (I_READ_ENABLE) begin
      sel_valid <= in_range;
      sel_row   <= I_PIXEL_ROW;
    end
  end

  assign O_PIXEL = sel_valid ? line_q[sel_row] : '0;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed scenarios plus random traffic against an associative-array model of the store.
module tb_frame_buffer;
  import edge_detect_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  col;
  logic [1:0]  row;
  logic [23:0] pix;
  logic        we;
  logic        re;
  logic [23:0] o_pixel;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] mem_m [int];
  logic [23:0] exp_pix;
  bit          exp_known = 1'b0;

  always #5 clk = ~clk;

  frame_buffer dut (
    .I_CLK         (clk),
    .I_RESET       (rst),
    .I_PIXEL_COL   (col),
    .I_PIXEL_ROW   (row),
    .I_PIXEL       (pix),
    .I_WRITE_ENABLE(we),
    .I_READ_ENABLE (re),
    .O_PIXEL       (o_pixel)
  );

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, let the edge happen, update the model, check away from the edge.
  task automatic cyc(input bit r, input bit w, input bit rd, input int c, input int rw,
                     input logic [23:0] p, input string tag);
    bit inr;
    int key;
    rst = r; we = w; re = rd; col = 10'(c); row = 2'(rw); pix = p;
    @(posedge clk);
    inr = (c < COLUMNS) && (rw < ROWS);
    key = rw * 1024 + c;
    if (r) begin
      exp_pix   = '0;
      exp_known = 1'b1;
    end else begin
      if (rd) begin
        if (!inr) begin
          exp_pix = '0; exp_known = 1'b1;
        end else if (mem_m.exists(key)) begin
          exp_pix = mem_m[key]; exp_known = 1'b1;
        end else begin
          exp_known = 1'b0;
        end
      end
      if (w && inr) mem_m[key] = p;
    end
    @(negedge clk);
    if (exp_known) check(tag, o_pixel, exp_pix);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; col = '0; row = '0; pix = '0;

    // Reset, then hold with reads idle
    cyc(1, 0, 0, 0, 0, 24'h0, "reset");
    check("reset_zero", o_pixel, 24'h000000);
    cyc(0, 0, 0, 0, 0, 24'h0, "hold0");
    cyc(0, 0, 0, 0, 0, 24'h0, "hold1");

    // Basic write then read
    cyc(0, 1, 0, 0, 0, WHITE, "wr_0_0");
    cyc(0, 0, 1, 0, 0, 24'h0, "rd_0_0");
    check("white_0_0", o_pixel, 24'hFFFFFF);

    // Far corner, and earlier data survives
    cyc(0, 1, 0, 639, 2, RED, "wr_639_2");
    cyc(0, 0, 1, 639, 2, 24'h0, "rd_639_2");
    check("red_639_2", o_pixel, 24'hFF0000);
    cyc(0, 0, 1, 0, 0, 24'h0, "reread_0_0");
    check("white_again", o_pixel, 24'hFFFFFF);

    // Same-edge read and write: old data out
    cyc(0, 1, 0, 5, 1, 24'h123456, "wr_5_1_old");
    cyc(0, 1, 1, 5, 1, 24'hABCDEF, "rw_5_1");
    check("rbw_old", o_pixel, 24'h123456);
    cyc(0, 0, 1, 5, 1, 24'h0, "rd_5_1_new");
    check("rbw_new", o_pixel, 24'hABCDEF);
    cyc(0, 0, 0, 0, 0, 24'h0, "idle_hold");
    check("idle_hold_val", o_pixel, 24'hABCDEF);

    // Out-of-range accesses
    cyc(0, 1, 0, 700, 0, 24'h00FF00, "wr_col700");
    cyc(0, 1, 0, 0, 3, 24'h00FF00, "wr_row3");
    cyc(0, 1, 0, 700, 3, 24'h00FF00, "wr_both_oor");
    cyc(0, 0, 1, 700, 0, 24'h0, "rd_col700");
    check("oor_col_zero", o_pixel, 24'h000000);
    cyc(0, 0, 1, 0, 0, 24'h0, "oor_keep_0_0");
    cyc(0, 0, 1, 639, 2, 24'h0, "oor_keep_639_2");
    cyc(0, 0, 1, 5, 1, 24'h0, "oor_keep_5_1");
    cyc(0, 0, 1, 0, 3, 24'h0, "rd_row3");
    check("oor_row_zero", o_pixel, 24'h000000);
    cyc(0, 0, 1, 1023, 0, 24'h0, "rd_col1023");

    // Reset swallows a write and a read
    cyc(0, 1, 0, 1, 1, 24'h0000AA, "wr_1_1_prior");
    cyc(0, 0, 1, 5, 1, 24'h0, "load_nonzero");
    cyc(1, 1, 0, 1, 1, 24'h0000FF, "rst_with_wr");
    check("rst_wr_zero", o_pixel, 24'h000000);
    cyc(1, 0, 1, 5, 1, 24'h0, "rst_with_rd");
    cyc(0, 0, 1, 1, 1, 24'h0, "rd_1_1_after_rst");
    check("rst_wr_dropped", o_pixel, 24'h0000AA);

    // Random traffic over a small window plus out-of-range addresses
    for (int i = 0; i < 600; i++) begin
      bit r_rst, r_we, r_re;
      int r_col, r_row;
      r_rst = ($urandom_range(0, 49) == 0);
      r_we  = $urandom_range(0, 1);
      r_re  = $urandom_range(0, 1);
      r_col = ($urandom_range(0, 7) == 0) ? $urandom_range(630, 1023) : $urandom_range(0, 15);
      r_row = $urandom_range(0, 3);
      cyc(r_rst, r_we, r_re, r_col, r_row, 24'($urandom), "random");
    end

    cyc(0, 0, 0, 0, 0, 24'h0, "final_idle");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
